// File: rtl/cla_bist_pkg.sv
// Shared types and width helpers for the carry look-ahead adder self-test engines.
// Combinational definitions only: no latency, no flow control.
// Widths come from functions so each checker derives them from its own WIDTH.
package cla_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

    localparam int DEF_WIDTH = 4;

    // Total number of {cin, a, b} combinations swept for a given operand width.
    function automatic int num_vectors(input int width);
        return 2 ** (2 * width + 1);
    endfunction

    function automatic int idx_width(input int width);
        return 2 * width + 1;
    endfunction

    // One extra bit so a count of every vector failing still fits.
    function automatic int cnt_width(input int width);
        return 2 * width + 2;
    endfunction

    function automatic int res_width(input int width);
        return width + 1;
    endfunction

    localparam int DEF_IDX_W = idx_width(DEF_WIDTH);
    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);
    localparam int DEF_RES_W = res_width(DEF_WIDTH);

endpackage

// File: rtl/cla_golden_add.sv
// Reference adder: {cout, sum} = a + b + cin, the trusted result an ALU checker compares against.
// Purely combinational, zero cycles.
// No handshake; the output follows the inputs.
module cla_golden_add
    import cla_bist_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       cin,
    output logic [res_width(WIDTH)-1:0] res
);

    localparam int RW = res_width(WIDTH);

    always_comb begin
        res = RW'(a) + RW'(b) + RW'(cin);
    end

endmodule

// File: rtl/cla4_bist_checker.sv
// Exhaustive self-test sweep of a WIDTH-bit adder with error count and first-failure capture.
// Each vector takes SETTLE+1 cycles; done rises 2^(2*WIDTH+1)*(SETTLE+1) cycles after start.
// No backpressure; start is ignored while a sweep is running.
module cla4_bist_checker
    import cla_bist_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic [WIDTH-1:0]               dut_a,
    output logic [WIDTH-1:0]               dut_b,
    output logic                           dut_cin,
    input  logic [WIDTH-1:0]               dut_sum,
    input  logic                           dut_cout,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic [cnt_width(WIDTH)-1:0]    err_count,
    output logic [idx_width(WIDTH)-1:0]    first_fail_vec,
    output logic                           first_fail_valid
);

    localparam int IW = idx_width(WIDTH);
    localparam int CW = cnt_width(WIDTH);
    localparam int RW = res_width(WIDTH);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [IW-1:0]  LAST_IDX    = {IW{1'b1}};
    localparam logic [SW-1:0]  SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
    // With no settle time a freshly loaded vector is checked on the very next edge.
    localparam bist_state_t    ARM_STATE   = (SETTLE == 0) ? ST_CHECK : ST_WAIT;

    bist_state_t       state;
    logic [IW-1:0]     idx;
    logic [SW-1:0]     settle_cnt;
    logic [RW-1:0]     golden;
    logic              mismatch;

    cla_golden_add #(
        .WIDTH (WIDTH)
    ) u_golden (
        .a   (dut_a),
        .b   (dut_b),
        .cin (dut_cin),
        .res (golden)
    );

    always_comb begin
        mismatch = ({dut_cout, dut_sum} != golden);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            idx              <= '0;
            settle_cnt       <= '0;
            dut_a            <= '0;
            dut_b            <= '0;
            dut_cin          <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx                       <= '0;
                        settle_cnt                <= '0;
                        {dut_cin, dut_a, dut_b}   <= '0;
                        busy                      <= 1'b1;
                        done                      <= 1'b0;
                        pass                      <= 1'b0;
                        err_count                 <= '0;
                        first_fail_vec            <= '0;
                        first_fail_valid          <= 1'b0;
                        state                     <= ARM_STATE;
                    end
                end

                ST_WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                ST_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        if (!first_fail_valid) begin
                            first_fail_vec   <= idx;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        // Last vector stays on the adder; pass folds in this final compare.
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !mismatch && (err_count == CW'(0));
                        state <= ST_DONE;
                    end else begin
                        idx                     <= idx + 1'b1;
                        {dut_cin, dut_a, dut_b} <= idx + 1'b1;
                        state                   <= ARM_STATE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla4_bist_checker.sv
// Directed bench for the adder self-test engine with a behavioural adder that can carry injected faults.
module tb_cla4_bist_checker;
    import cla_bist_pkg::*;

    logic       clk;
    logic       rst_n;
    int         fault;

    // Checker with default settle time
    logic       start;
    logic [3:0] a, b, sum;
    logic       cin, cout;
    logic       busy, done, pass;
    logic [9:0] errc;
    logic [8:0] ffvec;
    logic       ffvalid;

    // Checker with zero settle time
    logic       start0;
    logic [3:0] a0, b0, sum0;
    logic       cin0, cout0;
    logic       busy0, done0, pass0;
    logic [9:0] errc0;
    logic [8:0] ffvec0;
    logic       ffvalid0;

    int compared;
    int mismatched;

    cla4_bist_checker #(.WIDTH(4), .SETTLE(1)) u_dut (
        .clk (clk), .rst_n (rst_n), .start (start),
        .dut_a (a), .dut_b (b), .dut_cin (cin),
        .dut_sum (sum), .dut_cout (cout),
        .busy (busy), .done (done), .pass (pass),
        .err_count (errc), .first_fail_vec (ffvec), .first_fail_valid (ffvalid)
    );

    cla4_bist_checker #(.WIDTH(4), .SETTLE(0)) u_dut0 (
        .clk (clk), .rst_n (rst_n), .start (start0),
        .dut_a (a0), .dut_b (b0), .dut_cin (cin0),
        .dut_sum (sum0), .dut_cout (cout0),
        .busy (busy0), .done (done0), .pass (pass0),
        .err_count (errc0), .first_fail_vec (ffvec0), .first_fail_valid (ffvalid0)
    );

    // Adder under test: 1 = carry-out stuck at 0, 2 = sum bit 0 inverted
    logic [4:0] r;
    always_comb begin
        r    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        sum  = r[3:0];
        cout = r[4];
        if (fault == 1) cout = 1'b0;
        if (fault == 2) sum[0] = ~r[0];
    end

    logic [4:0] r0;
    always_comb begin
        r0    = {1'b0, a0} + {1'b0, b0} + {4'b0, cin0};
        sum0  = r0[3:0];
        cout0 = r0[4];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 3000) begin
            tick(1);
            n++;
        end
    endtask

    int n;
    int exp_idx;
    int sb_bad;

    initial begin
        compared   = 0;
        mismatched = 0;
        fault      = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        start0     = 1'b0;
        tick(2);

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_errc", errc, 0);
        chk("rst_ffvec", ffvec, 0);
        chk("rst_ffvalid", ffvalid, 0);
        chk("rst_vec", {cin, a, b}, 0);
        rst_n = 1'b1;
        tick(2);

        // Correct adder, single start pulse
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t1_busy_e0", busy, 1);
        chk("t1_vec0", {cin, a, b}, 0);
        wait_done(n);
        chk("t1_cycles", n, 1024);
        chk("t1_busy", busy, 0);
        chk("t1_pass", pass, 1);
        chk("t1_errc", errc, 0);
        chk("t1_ffvalid", ffvalid, 0);
        chk("t1_last_vec", {cin, a, b}, 9'h1FF);

        // Carry-out stuck at 0
        fault = 1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t2_done_clr", done, 0);
        wait_done(n);
        chk("t2_cycles", n, 1024);
        chk("t2_errc", errc, 256);
        chk("t2_ffvec", ffvec, 9'h01F);
        chk("t2_ffvalid", ffvalid, 1);
        chk("t2_pass", pass, 0);

        // Sum bit 0 inverted: every vector fails
        fault = 2;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(n);
        chk("t3_errc", errc, 512);
        chk("t3_ffvec", ffvec, 0);
        chk("t3_ffvalid", ffvalid, 1);
        chk("t3_pass", pass, 0);

        // Reset around vector 100 discards the sweep
        fault = 1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(200);
        chk("t4_busy_mid", busy, 1);
        rst_n = 1'b0;
        tick(1);
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        chk("t4_pass", pass, 0);
        chk("t4_errc", errc, 0);
        chk("t4_ffvec", ffvec, 0);
        chk("t4_ffvalid", ffvalid, 0);
        chk("t4_vec", {cin, a, b}, 0);
        rst_n = 1'b1;
        fault = 0;
        tick(3);
        chk("t4_idle", {busy, done}, 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(n);
        chk("t4_cycles", n, 1024);
        chk("t4_pass2", pass, 1);

        // Start held through the sweep, then re-pulsed in DONE
        fault = 1;
        start = 1'b1;
        tick(1);
        wait_done(n);
        start = 1'b0;
        chk("t5_no_restart", n, 1024);
        chk("t5_errc", errc, 256);
        tick(3);
        chk("t5_done_hold", done, 1);
        chk("t5_errc_hold", errc, 256);
        fault = 0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t5_done_clr", done, 0);
        chk("t5_busy", busy, 1);
        chk("t5_errc_clr", errc, 0);
        chk("t5_ffvalid_clr", ffvalid, 0);
        wait_done(n);
        chk("t5_cycles", n, 1024);
        chk("t5_pass", pass, 1);

        // Zero settle time: one new vector per cycle, in order
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        exp_idx = 0;
        sb_bad  = 0;
        n       = 0;
        while (busy0 && n < 2000) begin
            if ({cin0, a0, b0} !== 9'(exp_idx)) sb_bad++;
            exp_idx++;
            tick(1);
            n++;
        end
        chk("t6_cycles", n, 512);
        chk("t6_vectors", exp_idx, num_vectors(4));
        chk("t6_order", sb_bad, 0);
        chk("t6_done", done0, 1);
        chk("t6_pass", pass0, 1);
        chk("t6_errc", errc0, 0);
        chk("t6_ffvalid", ffvalid0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
